// File: rtl/ticsat_out_banked_buf.sv
// Banked tile buffer: collects SA_SIZE rows per tile into NUM_BANKS banks and streams tiles out element by element.
// Define TICSAT_OUT_REG_EN to put a 2-entry skid buffer with registered outputs on the output side.
module ticsat_out_banked_buf #(
    parameter int SA_SIZE         = 4,
    parameter int ACTIVATION_SIZE = 32,
    parameter int NUM_BANKS       = 2
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [SA_SIZE*ACTIVATION_SIZE-1:0]  in_row,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                flush,
    output logic [ACTIVATION_SIZE-1:0]          out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic [$clog2(NUM_BANKS+1)-1:0]      banks_full
);
    localparam int RW = $clog2(SA_SIZE);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CW = $clog2(NUM_BANKS + 1);
    localparam int AW = ACTIVATION_SIZE;

    logic [SA_SIZE*AW-1:0] mem [NUM_BANKS][SA_SIZE];

    logic [BW-1:0] wr_bank_reg, rd_bank_reg;
    logic [RW-1:0] wr_row_reg, rd_row_reg, rd_col_reg;
    logic [CW-1:0] banks_full_reg;

    logic [SA_SIZE*AW-1:0] rd_row_data;
    logic [AW-1:0]         rd_elems [SA_SIZE];
    logic [AW-1:0]         s_data;
    logic                  s_valid, s_last, s_ready, s_fire, last_fire;
    logic                  wr_fire, commit;

    assign in_ready   = (banks_full_reg < CW'(NUM_BANKS));
    assign banks_full = banks_full_reg;
    assign wr_fire    = in_valid && in_ready;
    assign commit     = wr_fire && (wr_row_reg == RW'(SA_SIZE - 1));

    // Read side sees the oldest committed bank at the registered read address.
    assign rd_row_data = mem[rd_bank_reg][rd_row_reg];
    generate
        for (genvar gi = 0; gi < SA_SIZE; gi++) begin : g_elem
            assign rd_elems[gi] = rd_row_data[gi*AW +: AW];
        end
    endgenerate

    assign s_valid   = (banks_full_reg != '0);
    assign s_last    = s_valid && (rd_row_reg == RW'(SA_SIZE - 1)) && (rd_col_reg == RW'(SA_SIZE - 1));
    assign s_data    = s_valid ? rd_elems[rd_col_reg] : '0;
    assign s_fire    = s_valid && s_ready;
    assign last_fire = s_fire && s_last;

    always_ff @(posedge clk) begin
        if (wr_fire && !flush && !resetn) begin
            mem[wr_bank_reg][wr_row_reg] <= in_row;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn || flush) begin
            wr_bank_reg    <= '0;
            wr_row_reg     <= '0;
            rd_bank_reg    <= '0;
            rd_row_reg     <= '0;
            rd_col_reg     <= '0;
            banks_full_reg <= '0;
        end else begin
            if (wr_fire) begin
                if (wr_row_reg == RW'(SA_SIZE - 1)) begin
                    wr_row_reg  <= '0;
                    wr_bank_reg <= (wr_bank_reg == BW'(NUM_BANKS - 1)) ? '0 : wr_bank_reg + BW'(1);
                end else begin
                    wr_row_reg <= wr_row_reg + RW'(1);
                end
            end
            if (s_fire) begin
                if (rd_col_reg == RW'(SA_SIZE - 1)) begin
                    rd_col_reg <= '0;
                    if (rd_row_reg == RW'(SA_SIZE - 1)) begin
                        rd_row_reg  <= '0;
                        rd_bank_reg <= (rd_bank_reg == BW'(NUM_BANKS - 1)) ? '0 : rd_bank_reg + BW'(1);
                    end else begin
                        rd_row_reg <= rd_row_reg + RW'(1);
                    end
                end else begin
                    rd_col_reg <= rd_col_reg + RW'(1);
                end
            end
            // A commit and a bank release in the same cycle cancel out.
            case ({commit, last_fire})
                2'b10:   banks_full_reg <= banks_full_reg + CW'(1);
                2'b01:   banks_full_reg <= banks_full_reg - CW'(1);
                default: banks_full_reg <= banks_full_reg;
            endcase
        end
    end

`ifdef TICSAT_OUT_REG_EN
    logic [AW-1:0] out_data_reg, skid_data_reg;
    logic          out_valid_reg, out_last_reg, skid_valid_reg, skid_last_reg;

    // Upstream readiness depends only on the skid register, never on out_ready.
    assign s_ready   = !skid_valid_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

    always_ff @(posedge clk) begin
        if (resetn || flush) begin
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            skid_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_last_reg  <= 1'b0;
        end else if (out_ready || !out_valid_reg) begin
            if (skid_valid_reg) begin
                out_data_reg   <= skid_data_reg;
                out_last_reg   <= skid_last_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else begin
                out_data_reg  <= s_data;
                out_last_reg  <= s_last;
                out_valid_reg <= s_fire;
            end
        end else if (s_fire) begin
            skid_data_reg  <= s_data;
            skid_last_reg  <= s_last;
            skid_valid_reg <= 1'b1;
        end
    end
`else
    assign s_ready   = out_ready;
    assign out_data  = s_data;
    assign out_valid = s_valid;
    assign out_last  = s_last;
`endif

endmodule

// File: tb/tb_ticsat_out_banked_buf.sv
// Self-checking bench for ticsat_out_banked_buf: directed corner cases plus a randomized stall run against a queue model.
module tb_ticsat_out_banked_buf;
    localparam int SA = 4;
    localparam int AW = 32;
    localparam int NB = 2;
`ifdef TICSAT_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              resetn, in_valid, in_ready, flush, out_valid, out_ready, out_last;
    logic [SA*AW-1:0]  in_row;
    logic [AW-1:0]     out_data;
    logic [1:0]        banks_full;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ticsat_out_banked_buf #(.SA_SIZE(SA), .ACTIVATION_SIZE(AW), .NUM_BANKS(NB)) dut (
        .clk(clk), .resetn(resetn), .in_row(in_row), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .banks_full(banks_full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tile with base b holds element (r,c) = b + 16r + c.
    function automatic logic [SA*AW-1:0] tile_row(int base, int r);
        logic [SA*AW-1:0] v;
        v = '0;
        for (int c = 0; c < SA; c++) v[c*AW +: AW] = AW'(base + 16*r + c);
        return v;
    endfunction

    function automatic logic [AW-1:0] tile_elem(int base, int i);
        return AW'(base + 16*(i / SA) + (i % SA));
    endfunction

    task automatic write_rows(int base, int first, int n);
        for (int r = first; r < first + n; r++) begin
            in_valid = 1'b1;
            in_row   = tile_row(base, r);
            $display("row  base=%0d r=%0d in_ready=%b", base, r, in_ready);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_row = '0;
        tick(); tick();
        n_checks++; if (banks_full !== 2'd0) begin n_fail++; $display("FAIL reset_banks_full got=%0d exp=0", banks_full); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        resetn = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int r = 0; r < SA; r++) begin
            in_valid = 1'b1;
            in_row   = tile_row(0, r);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready r=%0d got=%b exp=1", r, in_ready); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid r=%0d got=%b exp=0", r, out_valid); end
            tick();
        end
        in_valid = 1'b0;
        for (int w = 0; w < LAT - 1; w++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency got=%b exp=0", out_valid); end
            tick();
        end
        for (int i = 0; i < SA*SA; i++) begin
            $display("out  basic i=%0d data=%0d last=%b", i, out_data, out_last);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid i=%0d got=%b exp=1", i, out_valid); end
            n_checks++; if (out_data !== tile_elem(0, i)) begin n_fail++; $display("FAIL basic_data i=%0d got=%0d exp=%0d", i, out_data, tile_elem(0, i)); end
            n_checks++; if (out_last !== (i == SA*SA-1)) begin n_fail++; $display("FAIL basic_last i=%0d got=%b exp=%b", i, out_last, (i == SA*SA-1)); end
            tick();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done_valid got=%b exp=0", out_valid); end
        n_checks++; if (banks_full !== 2'd0) begin n_fail++; $display("FAIL basic_done_full got=%0d exp=0", banks_full); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_and_last();
        int got;
        out_ready = 1'b0;
        write_rows(256, 0, SA);
        write_rows(512, 0, SA);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (banks_full !== 2'd2) begin n_fail++; $display("FAIL full_count got=%0d exp=2", banks_full); end
        for (int r = 0; r < SA; r++) begin
            in_valid = 1'b1;
            in_row   = tile_row(768, r);
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ignore r=%0d in_ready got=%b exp=0", r, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (banks_full !== 2'd2) begin n_fail++; $display("FAIL full_hold got=%0d exp=2", banks_full); end
`ifndef TICSAT_OUT_REG_EN
        out_ready = 1'b1;
        for (int i = 0; i < SA*SA; i++) begin
            if (i == SA*SA-1) begin
                in_valid = 1'b1;
                in_row   = tile_row(3840, 0);
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lastread_in_ready got=%b exp=0", in_ready); end
            end
            $display("out  full i=%0d data=%0d last=%b", i, out_data, out_last);
            n_checks++; if (out_data !== tile_elem(256, i)) begin n_fail++; $display("FAIL full_data i=%0d got=%0d exp=%0d", i, out_data, tile_elem(256, i)); end
            n_checks++; if (out_last !== (i == SA*SA-1)) begin n_fail++; $display("FAIL full_last i=%0d got=%b exp=%b", i, out_last, (i == SA*SA-1)); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (out_data !== tile_elem(512, 0)) begin n_fail++; $display("FAIL lastread_next got=%0d exp=%0d", out_data, tile_elem(512, 0)); end
`else
        got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && got < SA*SA; cyc++) begin
            if (out_valid) begin
                $display("out  full i=%0d data=%0d last=%b", got, out_data, out_last);
                n_checks++; if (out_data !== tile_elem(256, got)) begin n_fail++; $display("FAIL full_data i=%0d got=%0d exp=%0d", got, out_data, tile_elem(256, got)); end
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (got !== SA*SA) begin n_fail++; $display("FAIL full_read_count got=%0d exp=%0d", got, SA*SA); end
`endif
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lastread_rise got=%b exp=1", in_ready); end
        n_checks++; if (banks_full !== 2'd1) begin n_fail++; $display("FAIL lastread_count got=%0d exp=1", banks_full); end
        write_rows(1024, 0, SA);
        got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 2*SA*SA; cyc++) begin
            if (out_valid) begin
                $display("out  tail i=%0d data=%0d last=%b", got, out_data, out_last);
                n_checks++;
                if (out_data !== tile_elem((got < SA*SA) ? 512 : 1024, got % (SA*SA))) begin
                    n_fail++; $display("FAIL tail_data i=%0d got=%0d exp=%0d", got, out_data, tile_elem((got < SA*SA) ? 512 : 1024, got % (SA*SA)));
                end
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (got !== 2*SA*SA) begin n_fail++; $display("FAIL tail_count got=%0d exp=%0d", got, 2*SA*SA); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tail_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_coincide();
        int got;
        out_ready = 1'b0;
        write_rows(1280, 0, SA);
        write_rows(1536, 0, SA-1);
        got = 0;
`ifndef TICSAT_OUT_REG_EN
        out_ready = 1'b1;
        for (int i = 0; i < SA*SA; i++) begin
            if (i == SA*SA-1) begin
                in_valid = 1'b1;
                in_row   = tile_row(1536, SA-1);
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL coincide_in_ready got=%b exp=1", in_ready); end
            end
            n_checks++; if (out_data !== tile_elem(1280, i)) begin n_fail++; $display("FAIL coincide_data i=%0d got=%0d exp=%0d", i, out_data, tile_elem(1280, i)); end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (banks_full !== 2'd1) begin n_fail++; $display("FAIL coincide_count got=%0d exp=1", banks_full); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL coincide_valid got=%b exp=1", out_valid); end
        n_checks++; if (out_data !== tile_elem(1536, 0)) begin n_fail++; $display("FAIL coincide_next got=%0d exp=%0d", out_data, tile_elem(1536, 0)); end
        got = SA*SA;
`else
        write_rows(1536, SA-1, 1);
        out_ready = 1'b1;
`endif
        for (int cyc = 0; cyc < 200 && got < 2*SA*SA; cyc++) begin
            if (out_valid) begin
                $display("out  coincide i=%0d data=%0d last=%b", got, out_data, out_last);
                n_checks++;
                if (out_data !== tile_elem((got < SA*SA) ? 1280 : 1536, got % (SA*SA))) begin
                    n_fail++; $display("FAIL coincide_stream i=%0d got=%0d exp=%0d", got, out_data, tile_elem((got < SA*SA) ? 1280 : 1536, got % (SA*SA)));
                end
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (got !== 2*SA*SA) begin n_fail++; $display("FAIL coincide_total got=%0d exp=%0d", got, 2*SA*SA); end
        n_checks++; if (banks_full !== 2'd0) begin n_fail++; $display("FAIL coincide_empty got=%0d exp=0", banks_full); end
    endtask

    task automatic test_flush();
        int got;
        out_ready = 1'b0;
        write_rows(1792, 0, SA);
        write_rows(2048, 0, 2);
        flush = 1'b1; in_valid = 1'b1; in_row = tile_row(2048, 2);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (banks_full !== 2'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", banks_full); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL flush_last got=%b exp=0", out_last); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        write_rows(2304, 0, SA);
        got = 0;
        for (int cyc = 0; cyc < 100 && got < SA*SA; cyc++) begin
            if (out_valid) begin
                $display("out  flush i=%0d data=%0d last=%b", got, out_data, out_last);
                n_checks++; if (out_data !== tile_elem(2304, got)) begin n_fail++; $display("FAIL flush_data i=%0d got=%0d exp=%0d", got, out_data, tile_elem(2304, got)); end
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (got !== SA*SA) begin n_fail++; $display("FAIL flush_total got=%0d exp=%0d", got, SA*SA); end
        n_checks++; if (banks_full !== 2'd0) begin n_fail++; $display("FAIL flush_drained got=%0d exp=0", banks_full); end
    endtask

    task automatic test_random_stall();
        logic [AW-1:0]    exp_q[$];
        logic [AW-1:0]    exp_v, prev_data;
        logic [SA*AW-1:0] cur;
        logic             prev_stall, prev_last;
        bit               have;
        int               sent, got;
        cur = '0; have = 0; sent = 0; got = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < 3*SA*SA; cyc++) begin
            if (!have && sent < 3*SA) begin
                for (int c = 0; c < SA; c++) cur[c*AW +: AW] = $urandom;
                have = 1;
            end
            in_valid  = have && ($urandom_range(0, 3) != 0);
            in_row    = cur;
            out_ready = ($urandom_range(0, 2) != 0);
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    n_fail++; $display("FAIL stall_hold got=%b/%h/%b exp=1/%h/%b", out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                $display("out  rand i=%0d data=%h last=%b", got, out_data, out_last);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious got=%h exp=none", out_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (out_data !== exp_v || out_last !== (got % (SA*SA) == SA*SA-1)) begin
                        n_fail++; $display("FAIL rand_data i=%0d got=%h/%b exp=%h/%b", got, out_data, out_last, exp_v, (got % (SA*SA) == SA*SA-1));
                    end
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (in_valid && in_ready) begin
                for (int c = 0; c < SA; c++) exp_q.push_back(cur[c*AW +: AW]);
                sent++;
                have = 0;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (got !== 3*SA*SA) begin n_fail++; $display("FAIL rand_total got=%0d exp=%0d", got, 3*SA*SA); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_and_last();
        test_coincide();
        test_flush();
        test_random_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
